// File: rtl/uvmt_apb_adv_timer_apb_initiator.sv
// APB4 requester for the APB Advanced Timer register port.
// Turns a valid/ready command stream into single APB transfers and returns
// one valid/ready response per command.
// Optional watchdog: define UVMT_APB_ADV_TIMER_APB_INIT_TIMEOUT_EN to abort
// ACCESS phases that see pready=0 for TIMEOUT_CYCLES consecutive cycles.
//
// Handshake rule (cmd and rsp channels): a transfer happens on a rising clk
// edge where valid && ready are both 1; the producer holds valid and its
// payload stable until that edge, and ready never depends on valid.
module uvmt_apb_adv_timer_apb_initiator #(
    parameter int              ADDR_WIDTH     = 32,
    parameter int              DATA_WIDTH     = 32,
    parameter int              TIMEOUT_CYCLES = 256,
    parameter logic [2:0]      PPROT_VAL      = 3'b000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    // command channel
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    // response channel
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    output logic [15:0]             txn_count,
    // APB requester
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    output logic                    psel,
    output logic                    penable,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr,
    // debug: current FSM state (IDLE=0, SETUP=1, ACCESS=2, RESP=3)
    output logic [1:0]              fsm_state
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Reject unsupported configurations at elaboration time.
    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32) || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uvmt_apb_adv_timer_apb_initiator: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic                    cmd_fire;
    logic                    rsp_fire;
    logic                    access_done;
    logic                    access_abort;
    logic                    timeout_hit;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   strb_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    slverr_q;
    logic [15:0]             txn_q;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign rsp_fire = rsp_valid && rsp_ready;

`ifdef UVMT_APB_ADV_TIMER_APB_INIT_TIMEOUT_EN
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt;
    logic        timeout_q;

    // Count ACCESS cycles that stall; the cycle that would make the count
    // reach TIMEOUT_CYCLES aborts instead, unless pready completes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (cmd_fire) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !pready) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign timeout_hit = (wait_cnt == WAIT_LIMIT);

    // Timeout flag: cleared per command, set only by an abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_q <= 1'b0;
        end else if (cmd_fire) begin
            timeout_q <= 1'b0;
        end else if (access_abort) begin
            timeout_q <= 1'b1;
        end
    end

    assign rsp_timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and APB/handshake control decode.
    always_comb begin
        state_nxt    = state;
        cmd_ready    = 1'b0;
        psel         = 1'b0;
        penable      = 1'b0;
        rsp_valid    = 1'b0;
        access_done  = 1'b0;
        access_abort = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset_n so cmd_ready reads 0 while reset is held.
                cmd_ready = reset_n;
                if (cmd_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                psel      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    access_done = 1'b1;
                    state_nxt   = RESP;
                end else if (timeout_hit) begin
                    access_abort = 1'b1;
                    state_nxt    = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command capture and response data; reads never carry write data/strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
        end else begin
            if (cmd_fire) begin
                addr_q   <= cmd_addr;
                write_q  <= cmd_write;
                wdata_q  <= cmd_write ? cmd_wdata : '0;
                strb_q   <= cmd_write ? cmd_strb : '0;
                rdata_q  <= '0;
                slverr_q <= 1'b0;
            end
            if (access_done) begin
                rdata_q  <= write_q ? '0 : prdata;
                slverr_q <= pslverr;
            end
            if (access_abort) begin
                rdata_q  <= '0;
                slverr_q <= 1'b1;
            end
        end
    end

    // Completed-response counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txn_q <= '0;
        end else if (rsp_fire) begin
            txn_q <= txn_q + 16'd1;
        end
    end

    assign paddr      = addr_q;
    assign pwrite     = write_q;
    assign pwdata     = wdata_q;
    assign pstrb      = strb_q;
    assign pprot      = PPROT_VAL;
    assign rsp_rdata  = rdata_q;
    assign rsp_slverr = slverr_q;
    assign txn_count  = txn_q;
    assign fsm_state  = state;

endmodule
